// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, byte-serial fill of a direct-mapped icache,
// and a registered IF/ID boundary toward decode with stall and redirect handling.
module if_stage #(
  parameter logic [31:0] RESET_PC      = 32'h00000000,
  parameter int          CACHE_ENTRIES = 64,
  parameter logic [31:0] BUBBLE_INST   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic [31:0] inst_o,
  output logic [31:0] prediction_o,
  output logic        valid_o
);

  localparam int IW = $clog2(CACHE_ENTRIES);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        buf_q, buf_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic [31:0]        npc_q, npc_d;
  logic [31:0]        pred_q, pred_d;
  logic [31:0]        inst_q, inst_d;
  logic               valid_q, valid_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [CACHE_ENTRIES-1:0] line_valid_q, line_valid_d;

  logic [31:0]        line_mem [CACHE_ENTRIES];
  logic [TW-1:0]      tag_mem  [CACHE_ENTRIES];

  logic [IW-1:0]      idx;
  logic [TW-1:0]      tag;
  logic               hit;
  logic               cache_we;
  logic [1:0]         next_cnt;
  logic               unused_bits;

  assign idx         = pc_q[IW+1:2];
  assign tag         = pc_q[31:IW+2];
  assign hit         = line_valid_q[idx] && (tag_mem[idx] == tag);
  assign next_cnt    = byte_cnt_q + 2'd1;
  assign unused_bits = ^{jmp_addr_i[1:0], buf_q[31:24]};

  // The fill always targets pc_q: pc only moves during a fill on a redirect,
  // and a redirect aborts the fill before any cache write.
  always_ff @(posedge clk) begin
    if (cache_we) begin
      line_mem[idx] <= {mem_data_i, buf_q[23:0]};
      tag_mem[idx]  <= tag;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    byte_cnt_d   = byte_cnt_q;
    buf_d        = buf_q;
    pc_out_d     = pc_out_q;
    npc_d        = npc_q;
    pred_d       = pred_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_valid_d = line_valid_q;
    cache_we     = 1'b0;

    // Bubble whenever nothing is delivered, unless decode asked us to hold.
    if (jmp_i || !stall_i) begin
      inst_d  = BUBBLE_INST;
      valid_d = 1'b0;
    end
    if (jmp_i) begin
      pc_d = {jmp_addr_i[31:2], 2'b00};
    end

    case (state_q)
      IDLE: begin
        if (!jmp_i && !stall_i) begin
          if (hit) begin
            pc_out_d = pc_q;
            npc_d    = pc_q + 32'd4;
            pred_d   = pc_q + 32'd4;
            inst_d   = line_mem[idx];
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
          end else begin
            state_d    = FETCH;
            byte_cnt_d = 2'd0;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
      end

      FETCH: begin
        if (jmp_i) begin
          if (mem_ack_i) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = ABORT;
          end
        end else if (mem_ack_i) begin
          buf_d[{byte_cnt_q, 3'b000} +: 8] = mem_data_i;
          if (byte_cnt_q == 2'd3) begin
            cache_we          = 1'b1;
            line_valid_d[idx] = 1'b1;
            mem_req_d         = 1'b0;
            byte_cnt_d        = 2'd0;
            state_d           = IDLE;
          end else begin
            byte_cnt_d = next_cnt;
            mem_addr_d = pc_q + {30'd0, next_cnt};
          end
        end
      end

      ABORT: begin
        // The outstanding byte must still be consumed; it is thrown away.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      byte_cnt_q   <= 2'd0;
      buf_q        <= 32'd0;
      pc_out_q     <= 32'd0;
      npc_q        <= 32'd0;
      pred_q       <= 32'd0;
      inst_q       <= BUBBLE_INST;
      valid_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      line_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      byte_cnt_q   <= byte_cnt_d;
      buf_q        <= buf_d;
      pc_out_q     <= pc_out_d;
      npc_q        <= npc_d;
      pred_q       <= pred_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign pc_o         = pc_out_q;
  assign npc_o        = npc_q;
  assign inst_o       = inst_q;
  assign prediction_o = pred_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a byte memory answers one cycle after each
// request, and every delivered instruction is popped against the queue.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_addr_i = 32'd0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_data_i = 8'd0;
  logic [31:0] pc_o, npc_o, inst_o, prediction_o;
  logic        valid_o;

  if_stage #(
    .RESET_PC(32'h00000000), .CACHE_ENTRIES(64), .BUBBLE_INST(32'h00000000)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .jmp_i(jmp_i), .jmp_addr_i(jmp_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .pc_o(pc_o), .npc_o(npc_o), .inst_o(inst_o),
    .prediction_o(prediction_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int reads = 0;
  logic        block_en = 1'b0;
  logic [31:0] block_addr = 32'd0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h00100513;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    w = w >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc = p;
    e.inst = word_at(p);
    exp_q.push_back(e);
  endtask

  // One clock: sample after the edge, score deliveries, then answer memory.
  task automatic tick();
    logic st, jp;
    exp_t e;
    st = stall_i;
    jp = jmp_i;
    @(posedge clk);
    #1;
    if (rst) begin
      if (jp) begin
        total++;
        if (valid_o !== 1'b0) begin
          bad++;
          $display("FAIL jmp_bubble: valid_o=%b required 0", valid_o);
        end
      end else if (!st && valid_o === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_delivery: pc_o=%h inst_o=%h, none required", pc_o, inst_o);
        end else begin
          e = exp_q.pop_front();
          if (pc_o !== e.pc || inst_o !== e.inst || npc_o !== e.pc + 32'd4 ||
              prediction_o !== e.pc + 32'd4) begin
            bad++;
            $display("FAIL delivery: pc=%h inst=%h npc=%h pred=%h required pc=%h inst=%h npc=pred=%h",
                     pc_o, inst_o, npc_o, prediction_o, e.pc, e.inst, e.pc + 32'd4);
          end else begin
            $display("deliver pc=%h inst=%h", pc_o, inst_o);
          end
        end
      end
    end
    if (!rst || mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_req_o && !(block_en && mem_addr_o == block_addr)) begin
      mem_ack_i  = 1'b1;
      mem_data_i = byte_at(mem_addr_o);
      reads++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d deliveries outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    jmp_i = 1'b1;
    jmp_addr_i = a;
    tick();
    jmp_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (valid_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'd0 || pc_o !== 32'd0 ||
        npc_o !== 32'd0 || prediction_o !== 32'd0 || inst_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b req=%b addr=%h pc=%h npc=%h pred=%h inst=%h required all 0",
               valid_o, mem_req_o, mem_addr_o, pc_o, npc_o, prediction_o, inst_o);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h valid=%b required 1/00000000/0",
               mem_req_o, mem_addr_o, valid_o);
    end
    $display("reset: req=%b addr=%h", mem_req_o, mem_addr_o);
  endtask

  task automatic test_cold_miss();
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    wait_drain("cold_miss");
    stall_i = 1'b1;
  endtask

  task automatic test_hit_loop();
    int r0;
    r0 = reads;
    redirect(32'd0);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL loop_bubble: valid_o=%b required 0", valid_o);
    end
    for (int i = 0; i < 3; i++) push_exp(32'(i * 4));
    tick();
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("FAIL loop_first_hit: valid_o=%b required 1", valid_o);
    end
    tick();
    tick();
    total++;
    if (exp_q.size() != 0 || reads != r0 || mem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL loop_no_mem: pending=%0d reads=%0d req=%b required 0/0/0",
               exp_q.size(), reads - r0, mem_req_o);
      exp_q.delete();
    end
    stall_i = 1'b1;
  endtask

  task automatic test_stall();
    redirect(32'd0);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    tick();
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc_o !== 32'd4 || inst_o !== word_at(32'd4) || valid_o !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold: pc=%h inst=%h valid=%b required %h/%h/1",
                 pc_o, inst_o, valid_o, 32'd4, word_at(32'd4));
      end
    end
    stall_i = 1'b0;
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_resume: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    stall_i = 1'b1;
  endtask

  task automatic test_abort();
    int n, r0;
    redirect(32'h40);
    block_en = 1'b1;
    block_addr = 32'h42;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h42) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL abort_setup: addr=%h req=%b required 00000042/1", mem_addr_o, mem_req_o);
    end
    jmp_i = 1'b1;
    jmp_addr_i = 32'h103;
    tick();
    jmp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h42) begin
        bad++;
        $display("FAIL abort_hold: req=%b addr=%h required 1/00000042", mem_req_o, mem_addr_o);
      end
      tick();
    end
    block_en = 1'b0;
    n = 0;
    while (!(mem_req_o && mem_addr_o != 32'h42) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (mem_addr_o !== 32'h100 || mem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_next_fetch: addr=%h req=%b required 00000100/1", mem_addr_o, mem_req_o);
    end
    push_exp(32'h100);
    wait_drain("abort_target");
    stall_i = 1'b1;
    r0 = reads;
    redirect(32'h40);
    push_exp(32'h40);
    wait_drain("abort_refetch");
    stall_i = 1'b1;
    total++;
    if (reads - r0 != 4) begin
      bad++;
      $display("FAIL abort_no_write: reads=%0d required 4", reads - r0);
    end
  endtask

  task automatic test_jmp_ack();
    int n, r0;
    redirect(32'h80);
    n = 0;
    while (!(mem_ack_i && mem_addr_o == 32'h81) && n < 40) begin
      tick();
      n++;
    end
    jmp_i = 1'b1;
    jmp_addr_i = 32'h0C;
    push_exp(32'h0C);
    tick();
    jmp_i = 1'b0;
    total++;
    if (mem_req_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL jmp_ack_idle: req=%b valid=%b required 0/0", mem_req_o, valid_o);
    end
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL jmp_ack_hit: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    stall_i = 1'b1;
    r0 = reads;
    redirect(32'h80);
    push_exp(32'h80);
    wait_drain("jmp_ack_refetch");
    stall_i = 1'b1;
    total++;
    if (reads - r0 != 4) begin
      bad++;
      $display("FAIL jmp_ack_no_write: reads=%0d required 4", reads - r0);
    end
  endtask

  task automatic test_alias();
    logic [31:0] seq [3];
    int r0;
    seq[0] = 32'h000;
    seq[1] = 32'h100;
    seq[2] = 32'h000;
    for (int i = 0; i < 3; i++) begin
      r0 = reads;
      redirect(seq[i]);
      push_exp(seq[i]);
      wait_drain("alias");
      stall_i = 1'b1;
      total++;
      if (reads - r0 != 4) begin
        bad++;
        $display("FAIL alias_miss: addr=%h reads=%0d required 4", seq[i], reads - r0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, r0;
    redirect(32'h200);
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h202) && n < 40) begin
      tick();
      n++;
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'd0 || pc_o !== 32'd0 ||
        npc_o !== 32'd0 || prediction_o !== 32'd0 || inst_o !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: valid=%b req=%b addr=%h pc=%h npc=%h pred=%h inst=%h required all 0",
               valid_o, mem_req_o, mem_addr_o, pc_o, npc_o, prediction_o, inst_o);
    end
    mem_ack_i = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b1;
    r0 = reads;
    tick();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_refetch_addr: req=%b addr=%h required 1/00000000", mem_req_o, mem_addr_o);
    end
    push_exp(32'd0);
    wait_drain("reset_refetch");
    total++;
    if (reads - r0 != 4) begin
      bad++;
      $display("FAIL reset_cache_clear: reads=%0d required 4", reads - r0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_loop();
    test_stall();
    test_abort();
    test_jmp_ack();
    test_alias();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Maintains the fetch PC and fetches 32-bit instructions over the byte-wide memory port, filling a small direct-mapped instruction cache.
- Delivers pc/npc/inst/prediction to decode through a registered IF/ID boundary.
- Honours stall from the hazard unit and redirect (jump/branch) from downstream; emits bubbles when it has no instruction.

Parameters:
RESET_PC, 32'h00000000, fetch PC after reset
CACHE_ENTRIES, 64, direct-mapped icache lines, one word each, power of two
BUBBLE_INST, 32'h00000000, instruction word driven when valid_o=0 (decoded as NOP)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst==0 resets)
stall_i  in  1  hold IF/ID outputs and fetch PC
jmp_i  in  1  redirect request, highest priority
jmp_addr_i  in  32  redirect target
mem_req_o  out  1  byte read request (level)
mem_addr_o  out  32  byte address
mem_ack_i  in  1  byte returned this cycle
mem_data_i  in  8  returned byte
pc_o  out  32  PC of inst_o
npc_o  out  32  pc_o+4
inst_o  out  32  instruction to decode
prediction_o  out  32  predicted next PC (static pc_o+4)
valid_o  out  1  inst_o is a real instruction

Behaviour:
- Reset (async, rst=0): fetch pc=RESET_PC; pc_o=npc_o=prediction_o=0; inst_o=BUBBLE_INST; valid_o=0; mem_req_o=0; mem_addr_o=0; all cache valid bits cleared; byte counter=0; state=IDLE. Reset mid-fill discards the fill.
- Cache: index=pc[log2(CACHE_ENTRIES)+1:2], tag=remaining upper bits; a hit requires valid bit set and tag match.
- States: IDLE, FETCH, ABORT.
- IDLE, hit, stall_i=0:
  - At the next edge: pc_o=pc, inst_o=line, npc_o=prediction_o=pc+4, valid_o=1, pc<=pc+4.
  - Sustained throughput is 1 inst/cycle.
- IDLE, miss: go to FETCH with k=0 and mem_req_o=1; do not deliver.
- FETCH:
  - Drive mem_addr_o=pc+k and hold mem_req_o=1 until mem_ack_i.
  - On each ack, store mem_data_i into buffer bits [8k+7:8k] (little-endian), then k++.
  - On the 4th ack, write buffer/tag into the cache, set the valid bit, set mem_req_o=0, return to IDLE.
  - The word is delivered via the hit path on the following cycle. Miss penalty = memory time + 1 cycle.
- While no instruction is produced and stall_i=0: at the edge, drive inst_o=BUBBLE_INST and valid_o=0; pc_o/npc_o keep their previous values.
- stall_i=1: all IF/ID outputs and fetch pc are held. An in-progress fill continues and writes the cache; delivery waits for stall release.
- jmp_i=1 (wins over stall_i and hit):
  - At the edge: pc <= {jmp_addr_i[31:2],2'b00}; outputs become bubble with valid_o=0.
  - If in FETCH with no ack this cycle: go to ABORT.
  - If an ack arrives in the same cycle as jmp_i: discard the byte, go to IDLE.
  - No cache write from an aborted fill.
- ABORT: a memory request cannot be withdrawn. Hold mem_req_o=1 and mem_addr_o unchanged until ack, discard the byte, set mem_req_o=0, go to IDLE. A further jmp_i in ABORT only updates pc.
- Arithmetic: 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0; byte addresses pc+k wrap the same way.
- Single outstanding byte request at all times.

Test Plan:
- Reset with rst=0 mid-run -> all outputs at reset values immediately (asynchronous); after release, first mem_addr_o=0 with mem_req_o=1.
- Cold miss at pc 0, memory returns 0x13,0x05,0x10,0x00 with 1-cycle latency -> inst_o=0x00100513, pc_o=0, npc_o=prediction_o=4, valid_o=1; bubbles (valid_o=0) on the preceding cycles.
- Loop back to 0 via jmp_i/jmp_addr_i=0 after cache fill -> 0x00100513 delivered one cycle after the bubble, no mem_req_o; consecutive hits give pc_o 0,4,8 on consecutive cycles.
- stall_i held 3 cycles during a hit stream -> pc_o/inst_o/valid_o unchanged for 3 cycles; resumes at next pc with no lost or duplicated instruction.
- Redirect cases:
  - jmp_i with jmp_addr_i=0x103 during FETCH, byte 2 outstanding -> ABORT holds the same mem_addr_o until ack; no cache write; next fetch at 0x100; a re-fetch of the old pc misses.
  - jmp_i coincident with ack -> immediate IDLE.
- Aliasing with 64 entries: fetch 0x000, then 0x100 (same index) -> 0x100 evicts 0x000; refetching 0x000 misses and returns the original word.
